// File: rtl/cmd_frame_pkg.sv
// Shared types and constants for the UART command-frame parser.
// States, status bytes returned to the host, and a small state-class helper.
package cmd_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REG,
        ST_LEN,
        ST_DATA,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [7:0] STAT_OK     = 8'hA5;
    localparam logic [7:0] STAT_NACK   = 8'hEE;
    localparam logic [7:0] STAT_BADLEN = 8'hE1;

    // States in which the parser is still collecting frame bytes from the host.
    function automatic logic is_rx_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_REG) || (s == ST_LEN) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/cmd_byte_fifo.sv
// Small show-ahead byte FIFO holding the write payload of one frame.
// A synchronous flush empties it regardless of concurrent push/pop.
module cmd_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push, pop;

    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cmd_frame_parser.sv
// Parses host command frames from a UART byte stream into I2C transaction
// descriptors, buffers write payload, relays read data and returns a status byte.
module cmd_frame_parser
    import cmd_frame_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [6:0]            cmd_dev_addr,
    output logic [6:0]            cmd_reg_addr,
    output logic                  cmd_rw,
    output logic                  cmd_conv,
    output logic [7:0]            cmd_len,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [DATA_WIDTH-1:0] m_wr_tdata,
    output logic                  m_wr_tvalid,
    input  logic                  m_wr_tready,
    input  logic [DATA_WIDTH-1:0] s_rd_tdata,
    input  logic                  s_rd_tvalid,
    output logic                  s_rd_tready,
    input  logic                  cmd_done,
    input  logic                  cmd_nack,
    output logic                  err_timeout
);
    localparam int              GW        = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [GW-1:0]   GAP_LAST  = GW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    state_t          state, state_nx;
    logic [6:0]      dev_addr_q, reg_addr_q;
    logic            rw_q, conv_q;
    logic [7:0]      len_q, byte_cnt_q;
    logic [7:0]      status_q, status_nx;
    logic [GW-1:0]   gap_cnt_q;
    logic            err_timeout_q;

    logic            rx_accept, gap_expired, len_ok, timeout_hit;
    logic            fifo_flush, fifo_wr, fifo_rd, fifo_empty, fifo_full;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    // Gated by rst so the host sees no ready while the block is held in reset.
    assign s_axis_tready = ~rst & is_rx_state(state);
    assign rx_accept     = s_axis_tvalid & s_axis_tready;
    assign gap_expired   = (gap_cnt_q == GAP_LAST);
    assign len_ok        = (s_axis_tdata != '0) && (s_axis_tdata <= MAX_LEN_B);

    assign cmd_dev_addr = dev_addr_q;
    assign cmd_reg_addr = reg_addr_q;
    assign cmd_rw       = rw_q;
    assign cmd_conv     = conv_q;
    assign cmd_len      = len_q;
    assign m_wr_tdata   = fifo_rd_data;
    assign err_timeout  = err_timeout_q;

    cmd_byte_fifo #(
        .DEPTH (MAX_LEN),
        .WIDTH (DATA_WIDTH)
    ) u_payload_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (fifo_flush),
        .wr_en   (fifo_wr),
        .wr_data (s_axis_tdata),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    always_comb begin
        state_nx      = state;
        status_nx     = status_q;
        timeout_hit   = 1'b0;
        fifo_flush    = 1'b0;
        fifo_wr       = 1'b0;
        fifo_rd       = 1'b0;
        cmd_valid     = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_wr_tvalid   = 1'b0;
        s_rd_tready   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_accept)
                    state_nx = ST_REG;
            end
            ST_REG: begin
                if (rx_accept)
                    state_nx = ST_LEN;
                else if (gap_expired)
                    timeout_hit = 1'b1;
            end
            ST_LEN: begin
                if (rx_accept) begin
                    if (!len_ok) begin
                        state_nx  = ST_RESP;
                        status_nx = STAT_BADLEN;
                    end else begin
                        state_nx = rw_q ? ST_ISSUE : ST_DATA;
                    end
                end else if (gap_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_accept) begin
                    fifo_wr = ~fifo_full;
                    if (byte_cnt_q == len_q - 8'd1)
                        state_nx = ST_ISSUE;
                end else if (gap_expired) begin
                    timeout_hit = 1'b1;
                end
            end
            ST_ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready)
                    state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (rw_q) begin
                    m_axis_tvalid = s_rd_tvalid;
                    m_axis_tdata  = s_rd_tdata;
                    s_rd_tready   = m_axis_tready;
                end else begin
                    m_wr_tvalid = ~fifo_empty;
                    fifo_rd     = m_wr_tready & ~fifo_empty;
                end
                if (cmd_done) begin
                    state_nx   = ST_RESP;
                    status_nx  = cmd_nack ? STAT_NACK : STAT_OK;
                    fifo_flush = 1'b1;
                end
            end
            ST_RESP: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = status_q;
                if (m_axis_tready)
                    state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (timeout_hit) begin
            state_nx   = ST_IDLE;
            fifo_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            status_q      <= '0;
            err_timeout_q <= 1'b0;
            dev_addr_q    <= '0;
            reg_addr_q    <= '0;
            rw_q          <= 1'b0;
            conv_q        <= 1'b0;
            len_q         <= '0;
            byte_cnt_q    <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state         <= state_nx;
            status_q      <= status_nx;
            err_timeout_q <= timeout_hit;
            if (rx_accept) begin
                case (state)
                    ST_IDLE: {dev_addr_q, rw_q} <= s_axis_tdata;
                    ST_REG:  {conv_q, reg_addr_q} <= s_axis_tdata;
                    ST_LEN: begin
                        len_q      <= s_axis_tdata;
                        byte_cnt_q <= '0;
                    end
                    ST_DATA: byte_cnt_q <= byte_cnt_q + 8'd1;
                    default: ;
                endcase
            end
            // Inter-byte gap: an accepted byte always restarts the count, even on expiry.
            if ((state == ST_REG || state == ST_LEN || state == ST_DATA) &&
                !rx_accept && !gap_expired)
                gap_cnt_q <= gap_cnt_q + GW'(1);
            else
                gap_cnt_q <= '0;
        end
    end

endmodule

// File: doc/cmd_frame_parser.md
CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 8, UART byte width (only 8 supported).
REQ-002 SHALL have parameter MAX_LEN, 16, max burst bytes per frame (2..255).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 100000, max inter-byte gap before frame abort.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  clock; rst  input  1  async active-high reset.
REQ-005 SHALL have ports s_axis_tdata/tvalid/tready  in/in/out  8/1/1  bytes from uart_rx.
REQ-006 SHALL have ports m_axis_tdata/tvalid/tready  out/out/in  8/1/1  bytes to uart_tx.
REQ-007 SHALL have ports cmd_dev_addr/cmd_reg_addr/cmd_rw/cmd_conv/cmd_len  out  7/7/1/1/8  transaction descriptor.
REQ-008 SHALL have ports cmd_valid/cmd_ready  out/in  1/1  descriptor handshake to I2C engine.
REQ-009 SHALL have ports m_wr_tdata/tvalid/tready  out/out/in  8/1/1  write payload to I2C engine.
REQ-010 SHALL have ports s_rd_tdata/tvalid/tready  in/in/out  8/1/1  read data from I2C engine.
REQ-011 SHALL have ports cmd_done/cmd_nack  in/in  1/1  engine completion pulse and NACK flag, sampled together.
REQ-012 SHALL have port err_timeout  out  1  one-cycle pulse on frame abort.

Function
REQ-013 Frame: byte0 {dev_addr[6:0], rw}; byte1 {conv, reg_addr[6:0]}; byte2 len; if rw=0, len payload bytes follow.
REQ-014 States: IDLE, REG, LEN, DATA, ISSUE, WAIT, RESP; byte0 accepted in IDLE -> REG; byte1 -> LEN.
REQ-015 LEN: len in 1..MAX_LEN and rw=0 -> DATA; valid and rw=1 -> ISSUE; len=0 or >MAX_LEN -> RESP with status 0xE1, no descriptor issued.
REQ-016 DATA: each accepted byte pushed to internal FIFO; after len-th byte -> ISSUE; descriptor issued only after whole frame buffered.
REQ-017 s_axis_tready SHALL be 1 only in IDLE, REG, LEN, DATA; 0 in ISSUE, WAIT, RESP.
REQ-018 ISSUE: cmd_valid=1 with stable descriptor until cmd_ready; transfer cycle -> WAIT.
REQ-019 WAIT, rw=0: FIFO drives m_wr_*; rw=1: s_rd_* forwarded combinationally to m_axis_* (s_rd_tready = m_axis_tready).
REQ-020 WAIT: cmd_done -> RESP; status 0xA5 if cmd_nack=0, 0xEE if cmd_nack=1; FIFO flushed same cycle.
REQ-021 RESP: m_axis_tvalid=1 with status byte until m_axis_tready; transfer cycle -> IDLE.
REQ-022 Gap counter reset on every accepted byte, counts in REG/LEN/DATA; reaching TIMEOUT_CYCLES-1 -> IDLE, err_timeout pulse, FIFO flushed, no status byte.
REQ-023 Byte accepted in same cycle counter expires: byte wins, no timeout.
REQ-024 cmd_done outside WAIT SHALL be ignored.
REQ-025 All AXI-stream valids SHALL hold data stable until ready; no combinational path s_axis_tvalid -> s_axis_tready.

Reset
REQ-026 On rst: state IDLE, FIFO empty, counters 0, all valid outputs 0, err_timeout 0, descriptor outputs 0, s_axis_tready 0 during reset.
REQ-027 rst mid-frame or mid-WAIT SHALL abandon the frame with no status byte; s_axis_tready=1 first cycle after deassertion.

Structure
REQ-028 Package cmd_frame_pkg SHALL hold state enum and status constants STAT_OK=0xA5, STAT_NACK=0xEE, STAT_BADLEN=0xE1.
REQ-029 Payload buffer SHALL be sub-module cmd_byte_fifo, depth MAX_LEN, width 8, sync flush input.
REQ-030 RTL target 120-400 lines total.

Verification
REQ-031 Write: 0x68,0x94,0x02,0x11,0x22 -> descriptor dev=0x34 rw=0 conv=1 reg=0x14 len=2; m_wr bytes 0x11,0x22; done nack=0 -> m_axis 0xA5.
REQ-032 Read: 0x69,0x80,0x03; engine returns 0x01,0x02,0x03 then done -> m_axis 0x01,0x02,0x03,0xA5.
REQ-033 Bad length: 0x68,0x00,0x00 -> no cmd_valid, m_axis 0xE1; len=MAX_LEN+1 -> same.
REQ-034 Timeout: 0x68 then silence TIMEOUT_CYCLES -> err_timeout pulse, IDLE, next full frame processed normally.
REQ-035 NACK + backpressure: done with nack=1, m_axis_tready low 10 cycles -> 0xEE held stable, then delivered once.
REQ-036 Reset mid-DATA after 1 of 4 payload bytes -> no descriptor, no status, FIFO empty, next frame correct.
